zx81_keymatrix: RTL and testbench



---
 rtl/zx81_kb_pkg.sv | 55 +++++
 rtl/zx81_keymatrix_if.sv | 12 +
 rtl/zx81_scancode_decode.sv | 56 +++++
 rtl/zx81_keymatrix.sv | 109 ++++++++++
 tb/tb_zx81_keymatrix.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/zx81_kb_pkg.sv
// Shared constants for the ZX81 keyboard matrix: set-2 scancodes, the matrix
// layout table and the compound-key identifiers.
package zx81_kb_pkg;

  localparam int unsigned ROWS                = 8;
  localparam int unsigned COLS                = 5;
  localparam int unsigned NUM_COMPOUND        = 6;
  localparam int unsigned RESET_PULSE_DEFAULT = 16;

  localparam logic [2:0] ROW_SHIFT = 3'd0;
  localparam logic [2:0] COL_SHIFT = 3'd0;
  localparam logic [2:0] ROW_ENTER = 3'd6;
  localparam logic [2:0] COL_ENTER = 3'd0;

  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_ENTER   = 8'h5A;
  localparam logic [7:0] SC_BKSP    = 8'h66;
  localparam logic [7:0] SC_COMMA   = 8'h41;
  localparam logic [7:0] SC_F12     = 8'h07;
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;

  typedef enum logic [2:0] {
    CMP_BKSP, CMP_LEFT, CMP_DOWN, CMP_UP, CMP_RIGHT, CMP_COMMA
  } compound_e;

  // Non-extended scancode at matrix position row*COLS+col (entry 0 is left SHIFT).
  localparam logic [7:0] KEY_CODE [ROWS*COLS] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h49, 8'h3A, 8'h31, 8'h32
  };

  // Base key {row, col} that a compound presses alongside SHIFT.
  function automatic logic [5:0] compound_base(input compound_e id);
    case (id)
      CMP_BKSP:  return {3'd4, 3'd0};
      CMP_LEFT:  return {3'd3, 3'd4};
      CMP_DOWN:  return {3'd4, 3'd4};
      CMP_UP:    return {3'd4, 3'd3};
      CMP_RIGHT: return {3'd4, 3'd2};
      CMP_COMMA: return {3'd7, 3'd1};
      default:   return {3'd4, 3'd0};
    endcase
  endfunction

endpackage

// File: rtl/zx81_keymatrix_if.sv
// Keyboard-side bus: PS/2 event word in, Z80 row select in, column data and
// status out.
interface zx81_keymatrix_if;
  logic [10:0] ps2_key;
  logic [7:0]  addr_hi;
  logic [4:0]  kb_cols;
  logic        key_event;
  logic        host_reset;

  modport master (output ps2_key, addr_hi, input kb_cols, key_event, host_reset);
  modport slave  (input ps2_key, addr_hi, output kb_cols, key_event, host_reset);
endinterface

// File: rtl/zx81_scancode_decode.sv
// Combinational set-2 scancode classifier for the ZX81 matrix.
module zx81_scancode_decode
  import zx81_kb_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output logic       valid_o,
  output logic       is_shift_o,
  output logic       is_compound_o,
  output compound_e  compound_id_o,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic       is_f12_o
);

  always_comb begin
    valid_o       = 1'b0;
    is_shift_o    = 1'b0;
    is_compound_o = 1'b0;
    compound_id_o = CMP_BKSP;
    row_o         = '0;
    col_o         = '0;
    is_f12_o      = 1'b0;
    if (!ext_i) begin
      for (int unsigned i = 0; i < ROWS*COLS; i++) begin
        if (code_i == KEY_CODE[i]) begin
          valid_o = 1'b1;
          row_o   = 3'(i / COLS);
          col_o   = 3'(i % COLS);
        end
      end
      case (code_i)
        SC_LSHIFT, SC_RSHIFT: begin
          valid_o    = 1'b1;
          is_shift_o = 1'b1;
          row_o      = ROW_SHIFT;
          col_o      = COL_SHIFT;
        end
        SC_BKSP:  begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_BKSP;  end
        SC_COMMA: begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_COMMA; end
        SC_F12:   begin valid_o = 1'b1; is_f12_o = 1'b1; end
        default: ;
      endcase
    end else begin
      case (code_i)
        SC_ENTER:   begin valid_o = 1'b1; row_o = ROW_ENTER; col_o = COL_ENTER; end
        SC_E_LEFT:  begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_LEFT;  end
        SC_E_DOWN:  begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_DOWN;  end
        SC_E_UP:    begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_UP;    end
        SC_E_RIGHT: begin valid_o = 1'b1; is_compound_o = 1'b1; compound_id_o = CMP_RIGHT; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/zx81_keymatrix.sv
// ZX81 8x5 key matrix fed by toggle-strobed PS/2 events, with compound keys
// and an F12 host-reset pulse.
module zx81_keymatrix
  import zx81_kb_pkg::*;
#(
  parameter bit          ENABLE_COMPOUND    = 1'b1,
  parameter int unsigned RESET_PULSE_CYCLES = RESET_PULSE_DEFAULT
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  zx81_keymatrix_if.slave  bus
);

  logic [ROWS-1:0][COLS-1:0] phys_q, phys_d, pressed;
  logic [NUM_COMPOUND-1:0]   comp_q, comp_d;
  logic                      lshift_q, lshift_d, rshift_q, rshift_d;
  logic                      key_event_q, key_event_d;
  logic [7:0]                pulse_q, pulse_d;
  logic                      primed_q, last_toggle_q;
  logic [COLS-1:0]           sel_or;

  logic       dec_valid, dec_shift, dec_compound, dec_f12, evt, recog, make;
  compound_e  dec_cid;
  logic [2:0] dec_row, dec_col;

  zx81_scancode_decode u_decode (
    .ext_i         (bus.ps2_key[8]),
    .code_i        (bus.ps2_key[7:0]),
    .valid_o       (dec_valid),
    .is_shift_o    (dec_shift),
    .is_compound_o (dec_compound),
    .compound_id_o (dec_cid),
    .row_o         (dec_row),
    .col_o         (dec_col),
    .is_f12_o      (dec_f12)
  );

  assign evt   = primed_q && (bus.ps2_key[10] != last_toggle_q);
  assign make  = bus.ps2_key[9];
  assign recog = dec_valid && (!dec_compound || ENABLE_COMPOUND);

  always_comb begin
    phys_d      = phys_q;
    comp_d      = comp_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    key_event_d = 1'b0;
    pulse_d     = (pulse_q != '0) ? pulse_q - 8'd1 : '0;
    if (evt && recog) begin
      key_event_d = 1'b1;
      if (dec_f12) begin
        if (make) pulse_d = 8'(RESET_PULSE_CYCLES);
      end else if (dec_shift) begin
        if (bus.ps2_key[7:0] == SC_RSHIFT) rshift_d = make;
        else                               lshift_d = make;
      end else if (dec_compound) begin
        comp_d[dec_cid] = make;
      end else begin
        phys_d[dec_row][dec_col] = make;
      end
    end
  end

  // Physical and compound sources are kept apart so each release only drops its own contribution.
  always_comb begin
    logic [5:0] base;
    base    = '0;
    pressed = phys_q;
    pressed[ROW_SHIFT][COL_SHIFT] = lshift_q | rshift_q | (|comp_q);
    for (int unsigned i = 0; i < NUM_COMPOUND; i++) begin
      base = compound_base(compound_e'(3'(i)));
      if (comp_q[i]) pressed[base[5:3]][base[2:0]] = 1'b1;
    end
  end

  always_comb begin
    sel_or = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!bus.addr_hi[r]) sel_or = sel_or | pressed[r];
    end
  end

  assign bus.kb_cols    = ~sel_or;
  assign bus.key_event  = key_event_q;
  assign bus.host_reset = (pulse_q != '0);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      phys_q        <= '0;
      comp_q        <= '0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      key_event_q   <= 1'b0;
      pulse_q       <= '0;
      primed_q      <= 1'b0;
      last_toggle_q <= 1'b0;
    end else begin
      phys_q        <= phys_d;
      comp_q        <= comp_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      key_event_q   <= key_event_d;
      pulse_q       <= pulse_d;
      primed_q      <= 1'b1;
      last_toggle_q <= bus.ps2_key[10];
    end
  end

endmodule

// File: tb/tb_zx81_keymatrix.sv
// Directed self-checking bench for zx81_keymatrix.
module tb_zx81_keymatrix;

  logic clk = 1'b0;
  logic rst_n;
  logic tog;
  int   n_cmp = 0;
  int   n_err = 0;

  zx81_keymatrix_if bus ();
  zx81_keymatrix_if bus0 ();

  assign bus0.ps2_key = bus.ps2_key;
  assign bus0.addr_hi = bus.addr_hi;

  zx81_keymatrix #(.ENABLE_COMPOUND(1'b1), .RESET_PULSE_CYCLES(16)) dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  zx81_keymatrix #(.ENABLE_COMPOUND(1'b0), .RESET_PULSE_CYCLES(16)) dut_nocomp (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic send(input logic mk, input logic ext, input logic [7:0] code);
    @(negedge clk);
    tog = ~tog;
    bus.ps2_key = {tog, mk, ext, code};
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tog = 1'b1;
    bus.ps2_key = {1'b1, 1'b0, 1'b0, 8'h00};
    bus.addr_hi = 8'h00;
    #3;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL rst_cols: got %b want 11111", bus.kb_cols); end
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL rst_event: got %b want 0", bus.key_event); end
    n_cmp++; if (bus.host_reset !== 1'b0) begin n_err++; $display("FAIL rst_hostrst: got %b want 0", bus.host_reset); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL prime_event: got %b want 0", bus.key_event); end
    idle();
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL idle_event: got %b want 0", bus.key_event); end
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL idle_cols: got %b want 11111", bus.kb_cols); end
  endtask

  task automatic test_single_key();
    send(1'b1, 1'b0, 8'h1A);
    n_cmp++; if (bus.key_event !== 1'b1) begin n_err++; $display("FAIL z_make_event: got %b want 1", bus.key_event); end
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11101) begin n_err++; $display("FAIL z_row0: got %b want 11101", bus.kb_cols); end
    bus.addr_hi = 8'hFD; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL z_row1: got %b want 11111", bus.kb_cols); end
    bus.addr_hi = 8'hFF; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL z_none: got %b want 11111", bus.kb_cols); end
    idle();
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL z_event_width: got %b want 0", bus.key_event); end
    send(1'b0, 1'b0, 8'h1A);
    n_cmp++; if (bus.key_event !== 1'b1) begin n_err++; $display("FAIL z_break_event: got %b want 1", bus.key_event); end
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL z_break_row0: got %b want 11111", bus.kb_cols); end
  endtask

  task automatic test_compound();
    send(1'b1, 1'b0, 8'h66);
    n_cmp++; if (bus0.key_event !== 1'b0) begin n_err++; $display("FAIL nocomp_event: got %b want 0", bus0.key_event); end
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11110) begin n_err++; $display("FAIL bksp_row0: got %b want 11110", bus.kb_cols); end
    n_cmp++; if (bus0.kb_cols !== 5'b11111) begin n_err++; $display("FAIL nocomp_row0: got %b want 11111", bus0.kb_cols); end
    bus.addr_hi = 8'hEF; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11110) begin n_err++; $display("FAIL bksp_row4: got %b want 11110", bus.kb_cols); end
    send(1'b1, 1'b0, 8'h12);
    send(1'b0, 1'b0, 8'h66);
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11110) begin n_err++; $display("FAIL lshift_hold_row0: got %b want 11110", bus.kb_cols); end
    bus.addr_hi = 8'hEF; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL bksp_rel_row4: got %b want 11111", bus.kb_cols); end
    send(1'b0, 1'b0, 8'h12);
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL lshift_rel_row0: got %b want 11111", bus.kb_cols); end
    send(1'b1, 1'b0, 8'h41);
    bus.addr_hi = 8'h7F; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11101) begin n_err++; $display("FAIL comma_row7: got %b want 11101", bus.kb_cols); end
    bus.addr_hi = 8'h7E; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11100) begin n_err++; $display("FAIL comma_rows07: got %b want 11100", bus.kb_cols); end
    send(1'b0, 1'b0, 8'h41);
    bus.addr_hi = 8'h00; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL comma_rel_all: got %b want 11111", bus.kb_cols); end
  endtask

  task automatic test_typematic();
    send(1'b1, 1'b1, 8'h74);
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11110) begin n_err++; $display("FAIL right_row0: got %b want 11110", bus.kb_cols); end
    bus.addr_hi = 8'hEF; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11011) begin n_err++; $display("FAIL right_row4: got %b want 11011", bus.kb_cols); end
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 8'h74);
    send(1'b0, 1'b1, 8'h74);
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL right_rel_row0: got %b want 11111", bus.kb_cols); end
    bus.addr_hi = 8'hEF; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL right_rel_row4: got %b want 11111", bus.kb_cols); end
    send(1'b1, 1'b1, 8'h12);
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL fake_shift_event: got %b want 0", bus.key_event); end
    bus.addr_hi = 8'h00; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL fake_shift_cols: got %b want 11111", bus.kb_cols); end
  endtask

  task automatic test_host_reset();
    send(1'b1, 1'b0, 8'h07);
    n_cmp++; if (bus.key_event !== 1'b1) begin n_err++; $display("FAIL f12_event: got %b want 1", bus.key_event); end
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL f12_cols: got %b want 11111", bus.kb_cols); end
    n_cmp++; if (bus.host_reset !== 1'b1) begin n_err++; $display("FAIL pulse_c0: got %b want 1", bus.host_reset); end
    for (int c = 1; c < 16; c++) begin
      idle();
      n_cmp++; if (bus.host_reset !== 1'b1) begin n_err++; $display("FAIL pulse_c%0d: got %b want 1", c, bus.host_reset); end
    end
    idle();
    n_cmp++; if (bus.host_reset !== 1'b0) begin n_err++; $display("FAIL pulse_end: got %b want 0", bus.host_reset); end
    send(1'b1, 1'b0, 8'h07);
    for (int c = 1; c < 10; c++) idle();
    send(1'b1, 1'b0, 8'h07);
    for (int c = 11; c < 26; c++) begin
      idle();
      n_cmp++; if (bus.host_reset !== 1'b1) begin n_err++; $display("FAIL reload_c%0d: got %b want 1", c, bus.host_reset); end
    end
    idle();
    n_cmp++; if (bus.host_reset !== 1'b0) begin n_err++; $display("FAIL reload_end: got %b want 0", bus.host_reset); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b0, 8'h15);
    send(1'b1, 1'b0, 8'h4D);
    bus.addr_hi = 8'hDB; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11110) begin n_err++; $display("FAIL qp_rows25: got %b want 11110", bus.kb_cols); end
    bus.addr_hi = 8'h00; #1;
    rst_n = 1'b0; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL async_clear: got %b want 11111", bus.kb_cols); end
    @(negedge clk);
    rst_n = 1'b1;
    tog = ~tog;
    bus.ps2_key = {tog, 1'b1, 1'b0, 8'h1A};
    idle();
    n_cmp++; if (bus.key_event !== 1'b0) begin n_err++; $display("FAIL reprime_event: got %b want 0", bus.key_event); end
    bus.addr_hi = 8'hFE; #1;
    n_cmp++; if (bus.kb_cols !== 5'b11111) begin n_err++; $display("FAIL reprime_cols: got %b want 11111", bus.kb_cols); end
    send(1'b1, 1'b0, 8'h1A);
    n_cmp++; if (bus.key_event !== 1'b1) begin n_err++; $display("FAIL post_rst_event: got %b want 1", bus.key_event); end
    n_cmp++; if (bus.kb_cols !== 5'b11101) begin n_err++; $display("FAIL post_rst_cols: got %b want 11101", bus.kb_cols); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_compound();
    test_typematic();
    test_host_reset();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
